// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM/parity types and helpers for the buffered UART transmitter.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  typedef enum logic [1:0] {PARITY_NONE, PARITY_EVEN, PARITY_ODD} parity_mode_e;
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction
  // Zero-extended data bits do not change the XOR, so narrower words share this function.
  function automatic logic parity_bit(input logic [8:0] data, input parity_mode_e mode);
    return (mode == PARITY_ODD) ? ~^data : ^data;
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with push/pop, full/empty flags and occupancy level.
module uart_tx_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   level
);
  localparam int Aw = $clog2(Depth);
  localparam int Lw = Aw + 1;
  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [Lw-1:0] level_q, level_d;
  always_comb begin
    wp_d = wp_q + Aw'(push);
    rp_d = rp_q + Aw'(pop);
    level_d = level_q + Lw'(push) - Lw'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      level_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      level_q <= level_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wp_q] <= wdata;
  assign rdata = mem_q[rp_q];
  assign full = level_q == Lw'(Depth);
  assign empty = level_q == '0;
  assign level = level_q;
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: parametrised UART TX with valid/ready write port and back-to-back frames.
// Define UART_TX_FIFO_EN for a FifoDepth-entry FIFO; otherwise a single holding register is used.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int ClockFreqHz  = 10000000,
  parameter int BaudRate     = 115200,
  parameter int DataBitsSize = 8,
  parameter int ParityMode   = 0,
  parameter int StopBitsSize = 1,
  parameter int FifoDepth    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DataBitsSize-1:0]      write_data,
  input  logic                         write,
  output logic                         write_ready,
  output logic                         tx_sig,
  output logic                         busy,
  output logic [$clog2(FifoDepth):0]   fifo_level
);
  localparam int Cpb = clks_per_bit(ClockFreqHz, BaudRate);
  localparam int Cw = (Cpb > 1) ? $clog2(Cpb) : 1;
  localparam int Lw = $clog2(FifoDepth) + 1;
`ifdef UART_TX_FIFO_EN
  localparam int Depth = FifoDepth;
`else
  localparam int Depth = 1;
`endif
  localparam logic [Cw-1:0] LastClk = Cw'(Cpb - 1);
  localparam logic [3:0] LastData = 4'(DataBitsSize - 1);
  localparam logic [3:0] LastStop = 4'(StopBitsSize - 1);
  localparam parity_mode_e Pm = parity_mode_e'(ParityMode);
  if (Cpb < 2) begin : g_bad_cpb
    $error("ClksPerBit must be at least 2");
  end
  if (DataBitsSize < 5 || DataBitsSize > 9) begin : g_bad_data
    $error("DataBitsSize must be 5..9");
  end
  if (ParityMode < 0 || ParityMode > 2) begin : g_bad_parity
    $error("ParityMode must be 0, 1 or 2");
  end
  if (StopBitsSize < 1 || StopBitsSize > 2) begin : g_bad_stop
    $error("StopBitsSize must be 1 or 2");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
    $error("FifoDepth must be a power of 2 and at least 2");
  end
  tx_state_e state_q, state_d;
  logic [Cw-1:0] clk_q, clk_d;
  logic [3:0] bit_q, bit_d;
  logic [DataBitsSize-1:0] shift_q, shift_d, rdata;
  logic par_q, par_d, tx_q, tx_d, write_ready_q, write_ready_d;
  logic push, pop, load, bit_end, full, empty;
  logic [Lw-1:0] level;
  assign push = write && write_ready_q;
  // Ready is registered, so it must anticipate the occupancy after this edge.
  assign write_ready_d = !(full ? !pop : (level == Lw'(Depth - 1)) && push && !pop);
`ifdef UART_TX_FIFO_EN
  uart_tx_fifo #(.Width(DataBitsSize), .Depth(FifoDepth)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .wdata(write_data), .pop(pop),
    .rdata(rdata), .full(full), .empty(empty), .level(level)
  );
`else
  logic [DataBitsSize-1:0] hold_q, hold_d;
  logic hold_valid_q, hold_valid_d;
  always_comb begin
    hold_d = push ? write_data : hold_q;
    hold_valid_d = push || (hold_valid_q && !pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end
  assign rdata = hold_q;
  assign full = hold_valid_q;
  assign empty = !hold_valid_q;
  assign level = Lw'(hold_valid_q);
`endif
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    par_d = par_q;
    load = 1'b0;
    bit_end = clk_q == LastClk;
    clk_d = (state_q == IDLE || bit_end) ? '0 : clk_q + 1'b1;
    tx_d = (state_q == START) ? 1'b0 : (state_q == DATA) ? shift_q[0] : (state_q == PARITY) ? par_q : 1'b1;
    case (state_q)
      IDLE: load = !empty;
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d = (bit_q == LastData) ? '0 : bit_q + 1'b1;
        if (bit_q == LastData) state_d = (Pm != PARITY_NONE) ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: if (bit_end) begin
        bit_d = (bit_q == LastStop) ? '0 : bit_q + 1'b1;
        if (bit_q == LastStop) begin
          state_d = IDLE;
          load = !empty;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = START;
      shift_d = rdata;
      par_d = parity_bit(9'(rdata), Pm);
      bit_d = '0;
    end
  end
  assign pop = load;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      clk_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
      write_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clk_q <= clk_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_q <= par_d;
      tx_q <= tx_d;
      write_ready_q <= write_ready_d;
    end
  end
  assign tx_sig = tx_q;
  assign write_ready = write_ready_q;
  assign busy = (state_q != IDLE) || (level != '0);
  assign fifo_level = level;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed vectors over 8N1/8E1/8O1/7N2 instances at 10 clks/bit.
module tb_uart_tx_buffered;
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic       wr  [4];
  logic [7:0] wd  [4];
  logic       rdy [4];
  logic       tx  [4];
  logic       bz  [4];
  logic [2:0] lvl [4];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_buffered #(.ClockFreqHz(10000000), .BaudRate(1000000), .DataBitsSize(8), .ParityMode(0), .StopBitsSize(1), .FifoDepth(4)) u_8n1 (
    .clk(clk), .rst(rst), .write_data(wd[0]), .write(wr[0]), .write_ready(rdy[0]), .tx_sig(tx[0]), .busy(bz[0]), .fifo_level(lvl[0]));
  uart_tx_buffered #(.ClockFreqHz(10000000), .BaudRate(1000000), .DataBitsSize(8), .ParityMode(1), .StopBitsSize(1), .FifoDepth(4)) u_8e1 (
    .clk(clk), .rst(rst), .write_data(wd[1]), .write(wr[1]), .write_ready(rdy[1]), .tx_sig(tx[1]), .busy(bz[1]), .fifo_level(lvl[1]));
  uart_tx_buffered #(.ClockFreqHz(10000000), .BaudRate(1000000), .DataBitsSize(8), .ParityMode(2), .StopBitsSize(1), .FifoDepth(4)) u_8o1 (
    .clk(clk), .rst(rst), .write_data(wd[2]), .write(wr[2]), .write_ready(rdy[2]), .tx_sig(tx[2]), .busy(bz[2]), .fifo_level(lvl[2]));
  uart_tx_buffered #(.ClockFreqHz(10000000), .BaudRate(1000000), .DataBitsSize(7), .ParityMode(0), .StopBitsSize(2), .FifoDepth(4)) u_7n2 (
    .clk(clk), .rst(rst), .write_data(wd[3][6:0]), .write(wr[3]), .write_ready(rdy[3]), .tx_sig(tx[3]), .busy(bz[3]), .fifo_level(lvl[3]));

  typedef struct {
    int          inst;
    logic [7:0]  d;
    int          nb;
    logic [11:0] exp;
  } vec_t;
  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // exp holds the line bits in transmit order, bit 0 = start bit.
  task automatic send_frame(input int i, input logic [7:0] d, input int nb, input logic [11:0] exp, input string nm);
    int t, bad;
    logic [11:0] got;
    t = 0;
    bad = 0;
    got = '0;
    @(negedge clk);
    while (!rdy[i] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({nm, " ready"}, 32'(rdy[i]), 1);
    wr[i] = 1'b1;
    wd[i] = d;
    @(negedge clk);
    wr[i] = 1'b0;
    chk({nm, " queued level"}, 32'(lvl[i]), 1);
    chk({nm, " busy on accept"}, 32'(bz[i]), 1);
    @(negedge clk);
    chk({nm, " line high before start"}, 32'(tx[i]), 1);
    @(negedge clk);
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < 10; c++) begin
        if (c == 5) got[k] = tx[i];
        if (tx[i] !== exp[k]) bad++;
        @(negedge clk);
      end
    end
    chk({nm, " bits"}, 32'(got), 32'(exp));
    chk({nm, " bit timing"}, bad, 0);
    chk({nm, " idle line"}, 32'(tx[i]), 1);
    chk({nm, " busy after frame"}, 32'(bz[i]), 0);
  endtask

  // Streams 5 bytes into the 8N1 instance, holding write high with junk data while not ready.
  task automatic stream(input logic [7:0] b [5], input string nm);
    fork
      begin
        int j, cyc;
        logic acc;
        j = 0;
        cyc = 0;
        while (j < 5 && cyc < 3000) begin
          @(negedge clk);
          acc = rdy[0];
          wr[0] = 1'b1;
          wd[0] = acc ? b[j] : 8'hEE;
          @(posedge clk);
          if (acc) j++;
          cyc++;
        end
        @(negedge clk);
        wr[0] = 1'b0;
        chk({nm, " all accepted"}, j, 5);
        chk({nm, " level when full"}, 32'(lvl[0]), DEPTH);
        chk({nm, " ready low when full"}, 32'(rdy[0]), 0);
      end
      begin
        int t, bad;
        logic [9:0] got, exp;
        t = 0;
        @(negedge clk);
        while (tx[0] && t < 40) begin
          @(negedge clk);
          t++;
        end
        chk({nm, " first start bit"}, 32'(tx[0]), 0);
        for (int f = 0; f < 5; f++) begin
          exp = {1'b1, b[f], 1'b0};
          bad = 0;
          got = '0;
          for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < 10; c++) begin
              if (c == 5) got[k] = tx[0];
              if (tx[0] !== exp[k]) bad++;
              @(negedge clk);
            end
          end
          chk($sformatf("%s frame%0d bits", nm, f), 32'(got), 32'(exp));
          chk($sformatf("%s frame%0d contiguous timing", nm, f), bad, 0);
        end
        chk({nm, " idle after stream"}, 32'(tx[0]), 1);
        chk({nm, " busy after stream"}, 32'(bz[0]), 0);
        chk({nm, " level after stream"}, 32'(lvl[0]), 0);
      end
    join
  endtask

  initial begin
    logic [7:0] s1 [5];
    logic [7:0] s2 [5];
    int t;
    s1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    s2 = '{8'h11, 8'h22, 8'h33, 8'hC3, 8'h3C};
    vt[0] = '{0, 8'hA5, 10, {2'b00, 1'b1, 8'hA5, 1'b0}};
    vt[1] = '{0, 8'h00, 10, {2'b00, 1'b1, 8'h00, 1'b0}};
    vt[2] = '{0, 8'hFF, 10, {2'b00, 1'b1, 8'hFF, 1'b0}};
    vt[3] = '{1, 8'hA5, 11, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}};
    vt[4] = '{1, 8'h07, 11, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}};
    vt[5] = '{2, 8'hA5, 11, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}};
    vt[6] = '{2, 8'h03, 11, {1'b0, 1'b1, 1'b1, 8'h03, 1'b0}};
    vt[7] = '{2, 8'h01, 11, {1'b0, 1'b1, 1'b0, 8'h01, 1'b0}};
    vt[8] = '{3, 8'h7F, 10, {2'b00, 2'b11, 7'h7F, 1'b0}};
    vt[9] = '{3, 8'h2A, 10, {2'b00, 2'b11, 7'h2A, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      wr[i] = 1'b0;
      wd[i] = 8'h00;
    end
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset tx%0d", i), 32'(tx[i]), 1);
      chk($sformatf("reset ready%0d", i), 32'(rdy[i]), 0);
      chk($sformatf("reset busy%0d", i), 32'(bz[i]), 0);
      chk($sformatf("reset level%0d", i), 32'(lvl[i]), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("ready after reset%0d", i), 32'(rdy[i]), 1);
    for (int v = 0; v < 10; v++) send_frame(vt[v].inst, vt[v].d, vt[v].nb, vt[v].exp, $sformatf("vec%0d", v));
    stream(s1, "stream 01-05");
    stream(s2, "held write");
    @(negedge clk);
    wr[0] = 1'b1;
    wd[0] = 8'h00;
    @(negedge clk);
    wr[0] = 1'b0;
    t = 0;
    while (tx[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (35) @(negedge clk);
    chk("mid-frame line low", 32'(tx[0]), 0);
    rst = 1'b1;
    #1;
    chk("abort tx high", 32'(tx[0]), 1);
    chk("abort level", 32'(lvl[0]), 0);
    chk("abort busy", 32'(bz[0]), 0);
    chk("abort ready", 32'(rdy[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready after abort", 32'(rdy[0]), 1);
    send_frame(0, 8'h5A, 10, {2'b00, 1'b1, 8'h5A, 1'b0}, "post-reset frame");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end
endmodule
